// File: rtl/double_trouble_pkg.sv
// Shared types and constants for the double_trouble evaluator and its arbiter.
package double_trouble_pkg;

   typedef logic [3:0] dt_vec_t;

   localparam int DT_THRESHOLD = 2;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} arb_state_e;

   function automatic logic [2:0] dt_popcount(input dt_vec_t v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

endpackage

// File: rtl/double_trouble.sv
// Combinational evaluator: out is 1 when at least DT_THRESHOLD of a,b,c,d are set.
module double_trouble
   import double_trouble_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
   output logic out
);

   always_comb out = (dt_popcount({d, c, b, a}) >= 3'(DT_THRESHOLD));

endmodule

// File: rtl/double_trouble_arbiter.sv
// Round-robin share of one double_trouble evaluator among NUM_REQ requesters.
// Optional statistics counters are enabled with `define DT_ARB_STATS_EN.
module double_trouble_arbiter
   import double_trouble_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [4*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output dt_vec_t              rsp_data,
   output logic                 rsp_out
`ifdef DT_ARB_STATS_EN
   ,
   output logic [15:0]          stat_accepts,
   output logic [15:0]          stat_true
`endif
);

   arb_state_e state_q, state_d;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] win;
   logic            found;
   logic            can_accept;
   logic            accept;
   logic [NUM_REQ-1:0][3:0] data_arr;
   dt_vec_t         win_data;
   logic            win_out;
   int              idx;

   assign data_arr = req_data;

   // First valid requester at or after rr_ptr, wrapping past NUM_REQ-1.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = ID_W'(idx);
         end
      end
   end

   // Reset also blocks grants so nothing is handshaken while the block is held.
   assign can_accept = !rst && ((state_q == EMPTY) || rsp_ready);
   assign accept     = can_accept && found;
   assign win_data   = data_arr[win];

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[win] = 1'b1;
   end

   double_trouble u_dt (
      .a   (win_data[0]),
      .b   (win_data[1]),
      .c   (win_data[2]),
      .d   (win_data[3]),
      .out (win_out)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (accept) state_d = FULL;
         FULL:    if (!accept && rsp_ready) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= EMPTY;
      else     state_q <= state_d;
   end

   assign rsp_valid = (state_q == FULL);

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr   <= '0;
         rsp_id   <= '0;
         rsp_data <= '0;
         rsp_out  <= 1'b0;
      end else if (accept) begin
         rr_ptr   <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
         rsp_id   <= win;
         rsp_data <= win_data;
         rsp_out  <= win_out;
      end
   end

`ifdef DT_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_accepts <= '0;
         stat_true    <= '0;
      end else if (accept) begin
         if (stat_accepts != 16'hFFFF) stat_accepts <= stat_accepts + 16'd1;
         if (win_out && stat_true != 16'hFFFF) stat_true <= stat_true + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_double_trouble_arbiter.sv
// Directed plus random bench for double_trouble_arbiter against a queue-free behavioural model.
module tb_double_trouble_arbiter;

   localparam int N = 4;
   localparam int W = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [4*N-1:0] req_data;
   logic [N-1:0]   req_ready;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [W-1:0]   rsp_id;
   logic [3:0]     rsp_data;
   logic           rsp_out;

   int vectors = 0;
   int miscompares = 0;

   // Reference state: what the consumer should be holding and who is next in line.
   bit       m_full;
   int       m_ptr;
   int       m_id;
   bit [3:0] m_data;
   bit       m_out;

   double_trouble_arbiter #(.NUM_REQ(N), .ID_W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_out   (rsp_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rsp();
      chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
      chk("rsp_id",    32'(rsp_id),    32'(m_id));
      chk("rsp_data",  32'(rsp_data),  32'(m_data));
      chk("rsp_out",   32'(rsp_out),   32'(m_out));
   endtask

   // One cycle: drive, check the combinational grant, advance model, check registered response.
   task automatic step(input logic [N-1:0] v, input logic [4*N-1:0] d, input logic rr, output int g);
      bit           can;
      logic [N-1:0] exp_rdy;
      @(negedge clk);
      req_valid = v;
      req_data  = d;
      rsp_ready = rr;
      #1;
      can = !m_full || rr;
      g = -1;
      if (can)
         for (int k = 0; k < N; k++)
            if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (g >= 0) begin
         m_full = 1;
         m_id   = g;
         m_data = d[4*g +: 4];
         m_out  = ($countones(m_data) >= 2);
         m_ptr  = (g + 1) % N;
      end else if (m_full && rr) begin
         m_full = 0;
      end
      @(posedge clk);
      #1;
      chk_rsp();
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst       = 1'b1;
      req_valid = '1;
      rsp_ready = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
      m_full = 0; m_ptr = 0; m_id = 0; m_data = 0; m_out = 0;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk_rsp();
      @(negedge clk);
      rst       = 1'b0;
      req_valid = '0;
   endtask

   initial begin
      int g;
      logic [4*N-1:0] d;
      logic [15:0]    true_mask;
      true_mask = 16'hFEE8;
      rst = 1'b1; req_valid = '1; req_data = '0; rsp_ready = 1'b0;

      // Reset with every requester asking
      do_reset(2);

      // Single request from requester 2
      d = '0; d[11:8] = 4'b0101;
      step(4'b0100, d, 1'b1, g);
      chk("single_out_1", 32'(rsp_out), 32'd1);
      d[11:8] = 4'b1000;
      step(4'b0100, d, 1'b1, g);
      chk("single_out_0", 32'(rsp_out), 32'd0);
      step(4'b0000, d, 1'b1, g);

      // Mid-operation reset while FULL, then fairness from requester 0
      step(4'b0010, 16'h0030, 1'b0, g);
      do_reset(1);
      for (int i = 0; i < 8; i++) begin
         step(4'b1111, {4'hF, 4'h6, 4'h1, 4'h3}, 1'b1, g);
         chk("fair_order", 32'(rsp_id), 32'(i % N));
         chk("fair_valid", 32'(rsp_valid), 32'd1);
      end

      // Backpressure: response and grants frozen, then accept on the release cycle
      for (int i = 0; i < 5; i++) step(4'b1111, 16'hA5C3, 1'b0, g);
      step(4'b1111, 16'hA5C3, 1'b1, g);
      chk("bp_release_grant", 32'(g), 32'd0);
      step(4'b0000, '0, 1'b1, g);

      // Exhaustive sweep on requester 1
      for (int v = 0; v < 16; v++) begin
         d = '0; d[7:4] = 4'(v);
         step(4'b0010, d, 1'b1, g);
         chk("sweep_out", 32'(rsp_out), 32'(true_mask[v]));
      end

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         d = 16'($urandom);
         step(4'($urandom), d, ($urandom_range(0, 3) != 0), g);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
